// File: rtl/fft_peak_detector.sv
// fft_peak_detector
//   Computes per-bin power (re^2 + im^2) from an FFT source stream, checks
//   sop/eop framing, and reports the strongest bin of each good frame.
//
//   Pipeline: input beat -> s1 (squares, tags) -> s2 (sum, mag outputs)
//             -> s3 (running max, peak/error outputs).
//
//   State table:
//     S_IDLE  | waiting for a sop beat; other beats are dropped
//     S_FRAME | accumulating bins 1..N_POINTS-1 of the current frame
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_src_valid/sop/eop   source beat qualifiers
//   i_src_real/imag       signed bin value (DW bits)
//   o_src_ready           low only while reset is asserted
//   o_mag_valid/data/bin  per-bin power, 2 cycles after the beat
//   o_peak_valid/bin/mag  good-frame result, 3 cycles after eop
//   o_frame_err           framing violation pulse, 3 cycles after the beat
//   o_frames_ok           saturating good-frame counter
module fft_peak_detector #(
  parameter int DW       = 25,
  parameter int N_POINTS = 1024,
  parameter int BW       = 10
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_src_valid,
  input  logic            i_src_sop,
  input  logic            i_src_eop,
  input  logic [DW-1:0]   i_src_real,
  input  logic [DW-1:0]   i_src_imag,
  output logic            o_src_ready,
  output logic            o_mag_valid,
  output logic [2*DW:0]   o_mag_data,
  output logic [BW-1:0]   o_mag_bin,
  output logic            o_peak_valid,
  output logic [BW-1:0]   o_peak_bin,
  output logic [2*DW:0]   o_peak_mag,
  output logic            o_frame_err,
  output logic [15:0]     o_frames_ok
);

  localparam logic [BW-1:0] LAST_BIN = BW'(N_POINTS - 1);

  typedef enum logic [0:0] {S_IDLE, S_FRAME} state_t;

  state_t              r_state;
  logic [BW-1:0]       r_bin;

  logic                r_s1_valid;
  logic                r_s1_first;
  logic                r_s1_last;
  logic                r_s1_err;
  logic [BW-1:0]       r_s1_bin;
  logic [2*DW-1:0]     r_s1_sq_re;
  logic [2*DW-1:0]     r_s1_sq_im;

  logic                r_s2_first;
  logic                r_s2_last;
  logic                r_s2_err;

  logic [2*DW:0]       r_max_mag;
  logic [BW-1:0]       r_max_bin;

  logic [BW-1:0]       w_bin_inc;
  logic signed [2*DW-1:0] w_sq_re;
  logic signed [2*DW-1:0] w_sq_im;
  logic [2*DW:0]       w_sum;
  logic                w_take_new;
  logic [2*DW:0]       w_max_mag;
  logic [BW-1:0]       w_max_bin;

  assign o_src_ready = ~i_reset;
  assign w_bin_inc   = r_bin + BW'(1);

  // Operands are sign-extended to the 2*DW result width, so the most
  // negative input squares exactly.
  assign w_sq_re = $signed(i_src_real) * $signed(i_src_real);
  assign w_sq_im = $signed(i_src_imag) * $signed(i_src_imag);
  assign w_sum   = {1'b0, r_s1_sq_re} + {1'b0, r_s1_sq_im};

  // Bin 0 always reloads; afterwards only a strictly larger power wins, so
  // ties keep the earliest bin.
  assign w_take_new = r_s2_first || (o_mag_data > r_max_mag);
  assign w_max_mag  = w_take_new ? o_mag_data : r_max_mag;
  assign w_max_bin  = w_take_new ? o_mag_bin  : r_max_bin;

  // Frame FSM and stage-1 tags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_bin   <= '0;
    end else begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_err   <= 1'b0;
      if (i_src_valid) begin
        case (r_state)
          S_IDLE: begin
            if (i_src_sop && i_src_eop) begin
              r_s1_err <= 1'b1;
            end else if (i_src_sop) begin
              r_state    <= S_FRAME;
              r_bin      <= '0;
              r_s1_valid <= 1'b1;
              r_s1_first <= 1'b1;
              r_s1_bin   <= '0;
            end
          end
          S_FRAME: begin
            if (i_src_sop && i_src_eop) begin
              r_s1_err <= 1'b1;
              r_state  <= S_IDLE;
            end else if (i_src_sop) begin
              // Abort the running frame; this beat restarts at bin 0.
              r_s1_err   <= 1'b1;
              r_bin      <= '0;
              r_s1_valid <= 1'b1;
              r_s1_first <= 1'b1;
              r_s1_bin   <= '0;
            end else begin
              r_bin      <= w_bin_inc;
              r_s1_valid <= 1'b1;
              r_s1_bin   <= w_bin_inc;
              if (w_bin_inc == LAST_BIN) begin
                r_state <= S_IDLE;
                if (i_src_eop) r_s1_last <= 1'b1;
                else           r_s1_err  <= 1'b1;
              end else if (i_src_eop) begin
                r_state  <= S_IDLE;
                r_s1_err <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Squares carry no control meaning, so they are left unreset.
  always_ff @(posedge i_clk) begin
    r_s1_sq_re <= w_sq_re;
    r_s1_sq_im <= w_sq_im;
  end

  // Stage 2: power sum and per-bin outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mag_valid <= 1'b0;
      o_mag_data  <= '0;
      o_mag_bin   <= '0;
      r_s2_first  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_err    <= 1'b0;
    end else begin
      o_mag_valid <= r_s1_valid;
      o_mag_data  <= w_sum;
      o_mag_bin   <= r_s1_bin;
      r_s2_first  <= r_s1_first;
      r_s2_last   <= r_s1_last;
      r_s2_err    <= r_s1_err;
    end
  end

  // Stage 3: running maximum and frame results.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_max_mag    <= '0;
      r_max_bin    <= '0;
      o_peak_valid <= 1'b0;
      o_peak_bin   <= '0;
      o_peak_mag   <= '0;
      o_frame_err  <= 1'b0;
      o_frames_ok  <= '0;
    end else begin
      o_peak_valid <= 1'b0;
      o_frame_err  <= r_s2_err;
      if (o_mag_valid) begin
        r_max_mag <= w_max_mag;
        r_max_bin <= w_max_bin;
        if (r_s2_last) begin
          o_peak_valid <= 1'b1;
          o_peak_bin   <= w_max_bin;
          o_peak_mag   <= w_max_mag;
          if (o_frames_ok != 16'hFFFF) o_frames_ok <= o_frames_ok + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/fft_peak_detector.md
FFT_PEAK_DETECTOR -- requirements
Module: fft_peak_detector

Interface
REQ-001 Parameter DW, default 25: signed width of src_real/src_imag, matching the FFT source output width.
REQ-002 Parameter N_POINTS, default 1024: FFT frame length in bins; legal range 2 to 65536.
REQ-003 Parameter BW, default 10: bin index width; SHALL satisfy 2^BW >= N_POINTS.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 src_valid  in  1  FFT source beat valid.
REQ-007 src_sop  in  1  first bin of frame, qualified by src_valid.
REQ-008 src_eop  in  1  last bin of frame, qualified by src_valid.
REQ-009 src_real  in  DW  signed real part of bin.
REQ-010 src_imag  in  DW  signed imaginary part of bin.
REQ-011 src_ready  out  1  0 while reset asserted, 1 otherwise; block never backpressures.
REQ-012 mag_valid  out  1  per-bin power output valid.
REQ-013 mag_data  out  2*DW+1  re^2 + im^2, unsigned.
REQ-014 mag_bin  out  BW  bin index of mag_data.
REQ-015 peak_valid  out  1  one-cycle pulse: completed frame result.
REQ-016 peak_bin  out  BW  bin index of maximum power in last good frame.
REQ-017 peak_mag  out  2*DW+1  maximum power in last good frame.
REQ-018 frame_err  out  1  one-cycle pulse: framing violation.
REQ-019 frames_ok  out  16  count of good frames, saturating at 65535.

Function
REQ-020 Power SHALL be computed in a 2-stage pipeline: stage 1 registers re^2 and im^2; stage 2 registers the sum; mag_valid/mag_data/mag_bin asserted exactly 2 cycles after the accepted beat.
REQ-021 Squares and sum SHALL be full precision, no truncation or saturation; (-2^(DW-1))^2 SHALL be exact.
REQ-022 Frame FSM states: IDLE (awaiting sop) and FRAME (accumulating); state, bin counter and tags SHALL advance only on src_valid beats; gaps in src_valid SHALL be tolerated.
REQ-023 IDLE: beat with sop=1, eop=0 -> bin 0, FRAME; beat without sop -> discarded, no mag_valid, no error.
REQ-024 FRAME: each beat increments the bin counter; beat with eop=1 at bin N_POINTS-1 -> good frame, IDLE.
REQ-025 FRAME: beat with sop=1 -> current frame aborted with frame_err, this beat becomes bin 0 of a new frame, stay FRAME.
REQ-026 FRAME: eop=1 at bin != N_POINTS-1, or bin N_POINTS-1 reached without eop -> frame_err, no peak result, IDLE.
REQ-027 sop=1 and eop=1 on the same beat SHALL be a framing error (frame_err); the beat SHALL be discarded and the FSM SHALL go to IDLE.
REQ-028 Running maximum SHALL reload at bin 0 and update only on strictly greater power; ties keep the lowest bin index.
REQ-029 peak_valid SHALL pulse exactly 3 cycles after the eop beat of a good frame; peak_bin/peak_mag SHALL update on that cycle and hold until the next good frame.
REQ-030 frame_err SHALL pulse exactly 3 cycles after the offending beat; the pipeline carries error and last-bin tags alongside data.
REQ-031 frames_ok SHALL increment in the peak_valid cycle, saturating at 65535.
REQ-032 mag outputs SHALL be produced for every accepted beat, including beats of frames later aborted.

Reset
REQ-033 While reset=1: FSM = IDLE, bin counter = 0, pipeline valids cleared, mag_valid = 0, peak_valid = 0, frame_err = 0, peak_bin = 0, peak_mag = 0, frames_ok = 0, src_ready = 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame and in-flight pipeline beats without any peak_valid or frame_err pulse.
REQ-035 After reset deasserts, the first beat SHALL be accepted on the next rising edge.

Verification (bench N_POINTS=8, DW=25)
REQ-036 Contiguous frame, bin3 = (re 1000, im -1000), all other bins 0 -> mag_data 2000000 at mag_bin 3; peak_valid 3 cycles after eop, with peak_bin 3, peak_mag 2000000, frames_ok 1.
REQ-037 Bins 2 and 5 both (300, 400), others 0 -> peak_bin 2, peak_mag 250000 (tie keeps lowest).
REQ-038 src_valid toggles 1,0,1,0 across the frame -> results identical to the contiguous case, with bin indices 0..7 in order.
REQ-039 eop at bin 5 -> frame_err 3 cycles later; no peak_valid; frames_ok unchanged; next proper frame -> good result.
REQ-040 sop at bin 4 -> frame_err; new frame completes 8 beats later with its own peak result; re = im = -2^24 in any bin -> mag_data 2^49 exactly.
REQ-041 reset pulsed at bin 6 -> no peak_valid or frame_err; all outputs at reset values; frames_ok 0.
